// File: rtl/ysyx_axi_pkg.sv
// Shared AXI types and constants for the ysyx standalone SRAM slave.
// Burst/response encodings, FSM states, grant priority and address-step helper.
package ysyx_axi_pkg;

   localparam int AXI_ID_W   = 4;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } axi_burst_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DATA,
      WR_DATA,
      WR_RESP
   } sram_state_e;

   typedef enum logic {
      PRIO_RD = 1'b0,
      PRIO_WR = 1'b1
   } prio_e;

   typedef struct packed {
      logic [31:0]         addr;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
      logic [AXI_ID_W-1:0] id;
   } ax_req_t;

   // WRAP intentionally steps like INCR; only FIXED holds the address.
   function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
      if (burst == FIXED) return addr;
      return addr + (32'd1 << size);
   endfunction

endpackage

// File: rtl/ysyx_axi_sram_array.sv
// Word-addressed storage split into one byte-wide array per lane.
// Combinational read, clocked byte-enabled write; contents are never reset.
module ysyx_axi_sram_array
   import ysyx_axi_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic                  clk_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic                  we_i,
   input  logic [AXI_STRB_W-1:0] wstrb_i,
   input  logic [AXI_DATA_W-1:0] wdata_i,
   output logic [AXI_DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   for (genvar gi = 0; gi < AXI_STRB_W; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clk_i) begin
         if (we_i && wstrb_i[gi]) begin
            mem_q[addr_i] <= wdata_i[8*gi +: 8];
         end
      end

      assign rdata_o[8*gi +: 8] = mem_q[addr_i];
   end

endmodule

// File: rtl/ysyx_axi_sram.sv
// AXI4 slave SRAM behind the core's io_master: one transaction at a time,
// round-robin AR/AW grant, configurable read latency, SLVERR on bad beats.
module ysyx_axi_sram
   import ysyx_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          ADDR_W     = 14,
   parameter int          RD_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            axi_arburst,
   input  logic [2:0]            axi_arsize,
   input  logic [7:0]            axi_arlen,
   input  logic [AXI_ID_W-1:0]   axi_arid,
   input  logic [31:0]           axi_araddr,
   input  logic                  axi_arvalid,
   output logic                  axi_arready,
   output logic [AXI_ID_W-1:0]   axi_rid,
   output logic                  axi_rlast,
   output logic [AXI_DATA_W-1:0] axi_rdata,
   output logic [1:0]            axi_rresp,
   output logic                  axi_rvalid,
   input  logic                  axi_rready,
   input  logic [1:0]            axi_awburst,
   input  logic [2:0]            axi_awsize,
   input  logic [7:0]            axi_awlen,
   input  logic [AXI_ID_W-1:0]   axi_awid,
   input  logic [31:0]           axi_awaddr,
   input  logic                  axi_awvalid,
   output logic                  axi_awready,
   input  logic                  axi_wlast,
   input  logic [AXI_DATA_W-1:0] axi_wdata,
   input  logic [AXI_STRB_W-1:0] axi_wstrb,
   input  logic                  axi_wvalid,
   output logic                  axi_wready,
   output logic [AXI_ID_W-1:0]   axi_bid,
   output logic [1:0]            axi_bresp,
   output logic                  axi_bvalid,
   input  logic                  axi_bready
);

   localparam int          DEPTH   = 2 ** ADDR_W;
   localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
   localparam logic [7:0]  LAT_CNT = 8'(RD_LATENCY);

   sram_state_e           state_q;
   prio_e                 prio_q;
   logic                  rvalid_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic                  err_q;
   logic [31:0]           addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [AXI_ID_W-1:0]   id_q;
   logic [7:0]            beat_q;
   logic [7:0]            cnt_q;

   ax_req_t               req_d;
   logic [31:0]           addr_d;
   logic                  idle;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  r_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  beat_err;
   logic                  last_beat;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_idx;
   logic [AXI_DATA_W-1:0] mem_rdata;

   // Ready is withheld while reset is asserted so nothing looks accepted then.
   assign idle        = reset && (state_q == IDLE);
   assign axi_arready = idle && (!axi_awvalid || prio_q == PRIO_RD);
   assign axi_awready = idle && (!axi_arvalid || prio_q == PRIO_WR);

   assign ar_hs = axi_arvalid && axi_arready;
   assign aw_hs = axi_awvalid && axi_awready;
   assign r_hs  = rvalid_q && axi_rready;
   assign w_hs  = wready_q && axi_wvalid;
   assign b_hs  = bvalid_q && axi_bready;

   always_comb begin
      req_d = '{addr: axi_awaddr, len: axi_awlen, size: axi_awsize,
                burst: axi_awburst, id: axi_awid};
      if (ar_hs) begin
         req_d = '{addr: axi_araddr, len: axi_arlen, size: axi_arsize,
                   burst: axi_arburst, id: axi_arid};
      end
   end

   assign beat_err  = ({1'b0, addr_q} < ADDR_LO) || ({1'b0, addr_q} >= ADDR_HI)
                      || (size_q > 3'd2);
   assign last_beat = (beat_q == len_q);
   assign addr_d    = axi_next_addr(addr_q, size_q, burst_q);
   assign mem_idx   = ADDR_W'((addr_q - BASE_ADDR) >> 2);
   assign mem_we    = reset && w_hs && !beat_err;

   ysyx_axi_sram_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i   (clock),
      .addr_i  (mem_idx),
      .we_i    (mem_we),
      .wstrb_i (axi_wstrb),
      .wdata_i (axi_wdata),
      .rdata_o (mem_rdata)
   );

   // Response fields derive from registered state and hold while the beat stalls.
   assign axi_rvalid = rvalid_q;
   assign axi_rid    = id_q;
   assign axi_rlast  = rvalid_q && last_beat;
   assign axi_rresp  = (rvalid_q && beat_err) ? SLVERR : OKAY;
   assign axi_rdata  = (rvalid_q && !beat_err) ? mem_rdata : '0;
   assign axi_wready = wready_q;
   assign axi_bvalid = bvalid_q;
   assign axi_bid    = id_q;
   assign axi_bresp  = err_q ? SLVERR : OKAY;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         prio_q   <= PRIO_RD;
         rvalid_q <= 1'b0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= FIXED;
         id_q     <= '0;
         beat_q   <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ar_hs || aw_hs) begin
                  addr_q  <= req_d.addr;
                  len_q   <= req_d.len;
                  size_q  <= req_d.size;
                  burst_q <= req_d.burst;
                  id_q    <= req_d.id;
                  beat_q  <= '0;
                  prio_q  <= (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
               end
               if (ar_hs) begin
                  if (RD_LATENCY == 0) begin
                     state_q  <= RD_DATA;
                     rvalid_q <= 1'b1;
                  end else begin
                     state_q <= RD_WAIT;
                     cnt_q   <= LAT_CNT;
                  end
               end else if (aw_hs) begin
                  state_q  <= WR_DATA;
                  wready_q <= 1'b1;
                  err_q    <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (cnt_q == 8'd1) begin
                  state_q  <= RD_DATA;
                  rvalid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  beat_q <= beat_q + 8'd1;
                  addr_q <= addr_d;
                  if (last_beat) begin
                     state_q  <= IDLE;
                     rvalid_q <= 1'b0;
                  end
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  beat_q <= beat_q + 8'd1;
                  addr_q <= addr_d;
                  // Bad address, oversize beat, or wlast disagreeing with len.
                  if (beat_err || (axi_wlast != last_beat)) begin
                     err_q <= 1'b1;
                  end
                  if (axi_wlast || last_beat) begin
                     state_q  <= WR_RESP;
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                  end
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  state_q  <= IDLE;
                  bvalid_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               rvalid_q <= 1'b0;
               wready_q <= 1'b0;
               bvalid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_axi_sram.sv
// Directed bench for ysyx_axi_sram with RD_LATENCY=2.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_ysyx_axi_sram;
   import ysyx_axi_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  axi_arburst = '0;
   logic [2:0]  axi_arsize = '0;
   logic [7:0]  axi_arlen = '0;
   logic [3:0]  axi_arid = '0;
   logic [31:0] axi_araddr = '0;
   logic        axi_arvalid = 1'b0;
   logic        axi_arready;
   logic [3:0]  axi_rid;
   logic        axi_rlast;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready = 1'b0;
   logic [1:0]  axi_awburst = '0;
   logic [2:0]  axi_awsize = '0;
   logic [7:0]  axi_awlen = '0;
   logic [3:0]  axi_awid = '0;
   logic [31:0] axi_awaddr = '0;
   logic        axi_awvalid = 1'b0;
   logic        axi_awready;
   logic        axi_wlast = 1'b0;
   logic [31:0] axi_wdata = '0;
   logic [3:0]  axi_wstrb = '0;
   logic        axi_wvalid = 1'b0;
   logic        axi_wready;
   logic [3:0]  axi_bid;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   ysyx_axi_sram #(
      .BASE_ADDR  (BASE),
      .ADDR_W     (14),
      .RD_LATENCY (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .axi_arburst (axi_arburst),
      .axi_arsize  (axi_arsize),
      .axi_arlen   (axi_arlen),
      .axi_arid    (axi_arid),
      .axi_araddr  (axi_araddr),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_rid     (axi_rid),
      .axi_rlast   (axi_rlast),
      .axi_rdata   (axi_rdata),
      .axi_rresp   (axi_rresp),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready),
      .axi_awburst (axi_awburst),
      .axi_awsize  (axi_awsize),
      .axi_awlen   (axi_awlen),
      .axi_awid    (axi_awid),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wlast   (axi_wlast),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bid     (axi_bid),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, output bit ok);
      axi_araddr  = addr;
      axi_arlen   = len;
      axi_arsize  = 3'd2;
      axi_arburst = INCR;
      axi_arid    = id;
      axi_arvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (axi_arready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      axi_arvalid = 1'b0;
   endtask

   task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, output bit ok);
      axi_awaddr  = addr;
      axi_awlen   = len;
      axi_awsize  = 3'd2;
      axi_awburst = INCR;
      axi_awid    = id;
      axi_awvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (axi_awready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      axi_awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb,
                         input logic last, output bit ok);
      axi_wdata  = data;
      axi_wstrb  = strb;
      axi_wlast  = last;
      axi_wvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (axi_wready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
   endtask

   task automatic b_recv(output logic [1:0] resp, output logic [3:0] id, output bit ok);
      axi_bready = 1'b1;
      ok = 1'b0;
      resp = 2'b11;
      id = '0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (axi_bvalid) begin
            ok = 1'b1;
            resp = axi_bresp;
            id = axi_bid;
            tick();
            break;
         end
         tick();
      end
      axi_bready = 1'b0;
   endtask

   task automatic r_recv(output logic [31:0] data, output logic [1:0] resp,
                         output logic last, output logic [3:0] id, output bit ok);
      axi_rready = 1'b1;
      ok = 1'b0;
      data = '0;
      resp = 2'b11;
      last = 1'b0;
      id = '0;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (axi_rvalid) begin
            ok = 1'b1;
            data = axi_rdata;
            resp = axi_rresp;
            last = axi_rlast;
            id = axi_rid;
            tick();
            break;
         end
         tick();
      end
      axi_rready = 1'b0;
   endtask

   task automatic wr_single(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id,
                            output logic [1:0] resp, output logic [3:0] bid);
      bit ok;
      aw_send(addr, 8'd0, id, ok);
      check("wr_aw_timeout", 32'(ok), 32'd1);
      w_send(data, strb, 1'b1, ok);
      check("wr_w_timeout", 32'(ok), 32'd1);
      b_recv(resp, bid, ok);
      check("wr_b_timeout", 32'(ok), 32'd1);
      $display("wr addr=%h data=%h strb=%b bresp=%0d bid=%h", addr, data, strb, resp, bid);
   endtask

   task automatic rd_single(input logic [31:0] addr, input logic [3:0] id,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic last, output logic [3:0] rid);
      bit ok;
      ar_send(addr, 8'd0, id, ok);
      check("rd_ar_timeout", 32'(ok), 32'd1);
      r_recv(data, resp, last, rid, ok);
      check("rd_r_timeout", 32'(ok), 32'd1);
      $display("rd addr=%h data=%h rresp=%0d rlast=%0d rid=%h", addr, data, resp, last, rid);
   endtask

   initial begin
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
      logic [1:0]  grant;
      logic [1:0]  exp_grant [4];
      bit          ok;
      int          lat;

      // Reset state
      repeat (3) tick();
      check("rst_arready", 32'(axi_arready), 32'd0);
      check("rst_awready", 32'(axi_awready), 32'd0);
      check("rst_rvalid", 32'(axi_rvalid), 32'd0);
      check("rst_wready", 32'(axi_wready), 32'd0);
      check("rst_bvalid", 32'(axi_bvalid), 32'd0);
      check("rst_ids", 32'({axi_rid, axi_bid}), 32'd0);
      check("rst_resps", 32'({axi_rresp, axi_bresp}), 32'd0);
      reset = 1'b1;
      tick();
      check("idle_after_reset", 32'(axi_arready), 32'd1);

      // Contended arbitration from reset: R, W, R, W (1=R, 2=W)
      exp_grant = '{2'd1, 2'd2, 2'd1, 2'd2};
      axi_araddr = BASE + 32'h200; axi_arlen = 8'd0; axi_arsize = 3'd2;
      axi_arburst = INCR; axi_arid = 4'h1;
      axi_awaddr = BASE + 32'h200; axi_awlen = 8'd0; axi_awsize = 3'd2;
      axi_awburst = INCR; axi_awid = 4'h2;
      for (int k = 0; k < 4; k++) begin
         axi_arvalid = 1'b1;
         axi_awvalid = 1'b1;
         grant = 2'd0;
         for (int t = 0; t < 64; t++) begin
            #1;
            grant = {axi_awready, axi_arready};
            if (grant != 2'd0) break;
            tick();
         end
         check("arb_grant", 32'(grant), 32'(exp_grant[k]));
         tick();
         if (grant == 2'd1) begin
            axi_arvalid = 1'b0;
            r_recv(data, resp, last, id, ok);
            check("arb_r_timeout", 32'(ok), 32'd1);
            $display("arb %0d read granted rid=%h", k, id);
         end else if (grant == 2'd2) begin
            axi_awvalid = 1'b0;
            w_send(32'h100 + 32'(k), 4'hF, 1'b1, ok);
            check("arb_w_timeout", 32'(ok), 32'd1);
            b_recv(resp, id, ok);
            check("arb_b_timeout", 32'(ok), 32'd1);
            $display("arb %0d write granted bid=%h", k, id);
         end else begin
            axi_arvalid = 1'b0;
            axi_awvalid = 1'b0;
            repeat (8) tick();
         end
      end
      axi_arvalid = 1'b0;
      axi_awvalid = 1'b0;
      tick();

      // Read latency and single-beat readback
      wr_single(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 4'h3, resp, id);
      check("lat_bresp", 32'(resp), 32'(OKAY));
      check("lat_bid", 32'(id), 32'h3);
      ar_send(BASE + 32'h10, 8'd0, 4'h5, ok);
      check("lat_ar_timeout", 32'(ok), 32'd1);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         #1;
         if (axi_rvalid) begin
            lat = n;
            break;
         end
         tick();
      end
      check("lat_cycles", 32'(lat), 32'd3);
      r_recv(data, resp, last, id, ok);
      $display("rd addr=%h data=%h rresp=%0d rlast=%0d rid=%h lat=%0d", BASE + 32'h10, data, resp, last, id, lat);
      check("lat_rdata", data, 32'hDEAD_BEEF);
      check("lat_rresp", 32'(resp), 32'(OKAY));
      check("lat_rlast", 32'(last), 32'd1);
      check("lat_rid", 32'(id), 32'h5);

      // INCR burst of 4 with a 3-cycle stall on beat 1
      aw_send(BASE, 8'd3, 4'h7, ok);
      check("bw_aw_timeout", 32'(ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         w_send(32'(i), 4'hF, (i == 3), ok);
         check("bw_w_timeout", 32'(ok), 32'd1);
      end
      b_recv(resp, id, ok);
      check("bw_bresp", 32'(resp), 32'(OKAY));
      $display("wr burst addr=%h len=3 bresp=%0d bid=%h", BASE, resp, id);
      ar_send(BASE, 8'd3, 4'h1, ok);
      check("br_ar_timeout", 32'(ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            axi_rready = 1'b0;
            for (int t = 0; t < 64; t++) begin
               #1;
               if (axi_rvalid) break;
               tick();
            end
            for (int s = 0; s < 3; s++) begin
               check("stall_rvalid", 32'(axi_rvalid), 32'd1);
               check("stall_rdata", axi_rdata, 32'd1);
               check("stall_rlast", 32'(axi_rlast), 32'd0);
               tick();
            end
         end
         r_recv(data, resp, last, id, ok);
         $display("rd burst beat=%0d data=%h rresp=%0d rlast=%0d rid=%h", i, data, resp, last, id);
         check("br_rdata", data, 32'(i));
         check("br_rlast", 32'(last), 32'(i == 3));
         check("br_rresp", 32'(resp), 32'(OKAY));
         check("br_rid", 32'(id), 32'h1);
      end
      check("br_back_idle", 32'(axi_arready), 32'd1);

      // Byte strobes: lanes 0 and 2 take the new data
      wr_single(BASE + 32'h40, 32'h1122_3344, 4'hF, 4'hA, resp, id);
      wr_single(BASE + 32'h40, 32'hAABB_CCDD, 4'b0101, 4'hA, resp, id);
      check("strb_bresp", 32'(resp), 32'(OKAY));
      check("strb_bid", 32'(id), 32'hA);
      rd_single(BASE + 32'h40, 4'h0, data, resp, last, id);
      check("strb_rdata", data, 32'h11BB_33DD);

      // Address range edges
      rd_single(32'h7FFF_FFFC, 4'h2, data, resp, last, id);
      check("low_oor_rresp", 32'(resp), 32'(SLVERR));
      check("low_oor_rdata", data, 32'd0);
      check("low_oor_rlast", 32'(last), 32'd1);
      rd_single(32'h8001_0000, 4'h2, data, resp, last, id);
      check("high_oor_rresp", 32'(resp), 32'(SLVERR));
      rd_single(32'h8000_FFFC, 4'h2, data, resp, last, id);
      check("top_word_rresp", 32'(resp), 32'(OKAY));

      // Early wlast on a 2-beat burst
      wr_single(BASE + 32'h84, 32'h0BAD_F00D, 4'hF, 4'h6, resp, id);
      aw_send(BASE + 32'h80, 8'd1, 4'h6, ok);
      check("ew_aw_timeout", 32'(ok), 32'd1);
      w_send(32'h55, 4'hF, 1'b1, ok);
      check("ew_w_timeout", 32'(ok), 32'd1);
      b_recv(resp, id, ok);
      $display("wr early-wlast addr=%h bresp=%0d bid=%h", BASE + 32'h80, resp, id);
      check("ew_bresp", 32'(resp), 32'(SLVERR));
      check("ew_bid", 32'(id), 32'h6);
      #1;
      check("ew_wready_off", 32'(axi_wready), 32'd0);
      tick();
      rd_single(BASE + 32'h84, 4'h0, data, resp, last, id);
      check("ew_beat1_kept", data, 32'h0BAD_F00D);
      rd_single(BASE + 32'h80, 4'h0, data, resp, last, id);
      check("ew_beat0_data", data, 32'h55);
      wr_single(BASE + 32'h90, 32'h1, 4'hF, 4'h6, resp, id);
      check("err_cleared_bresp", 32'(resp), 32'(OKAY));

      // Reset in the middle of a 4-beat write
      wr_single(BASE + 32'h108, 32'h1234_5678, 4'hF, 4'h9, resp, id);
      aw_send(BASE + 32'h100, 8'd3, 4'h9, ok);
      check("mr_aw_timeout", 32'(ok), 32'd1);
      w_send(32'hA0, 4'hF, 1'b0, ok);
      w_send(32'hA1, 4'hF, 1'b0, ok);
      reset = 1'b0;
      axi_wdata = 32'hA2;
      axi_wstrb = 4'hF;
      axi_wvalid = 1'b1;
      tick();
      reset = 1'b1;
      axi_wvalid = 1'b0;
      #1;
      $display("rst mid-burst wready=%0d bvalid=%0d arready=%0d", axi_wready, axi_bvalid, axi_arready);
      check("mr_wready", 32'(axi_wready), 32'd0);
      check("mr_bvalid", 32'(axi_bvalid), 32'd0);
      check("mr_idle", 32'(axi_arready), 32'd1);
      tick();
      rd_single(BASE + 32'h100, 4'h3, data, resp, last, id);
      check("mr_beat0", data, 32'hA0);
      rd_single(BASE + 32'h104, 4'h3, data, resp, last, id);
      check("mr_beat1", data, 32'hA1);
      rd_single(BASE + 32'h108, 4'h3, data, resp, last, id);
      check("mr_beat2_unwritten", data, 32'h1234_5678);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
